// File: rtl/cpu_types_pkg.sv
// Shared types and constants for the coherence controller and its arbiter.
package cpu_types_pkg;

    localparam int CPUS      = 2;
    localparam int BLK_WORDS = 2;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    // Controller FSM states, kept as plain constants so the encoding is fixed.
    typedef logic [2:0] cc_state_t;
    localparam cc_state_t IDLE = 3'd0;
    localparam cc_state_t IF   = 3'd1;
    localparam cc_state_t WB   = 3'd2;
    localparam cc_state_t SNP1 = 3'd3;
    localparam cc_state_t SNP2 = 3'd4;
    localparam cc_state_t LD   = 3'd5;
    localparam cc_state_t C2C  = 3'd6;

    // Kind of transaction the arbiter selected.
    typedef enum logic [1:0] {
        REQ_IF = 2'd0,
        REQ_WB = 2'd1,
        REQ_RD = 2'd2
    } req_kind_t;

endpackage

// File: rtl/cc_arbiter.sv
// Request selection among the two cores: dcache traffic beats icache
// traffic, ties go to the round-robin pointer rr.
module cc_arbiter
    import cpu_types_pkg::*;
(
    input  logic            CLK,
    input  logic            nRST,
    input  logic [CPUS-1:0] iREN,
    input  logic [CPUS-1:0] dREN,
    input  logic [CPUS-1:0] dWEN,
    input  logic            done,
    input  logic            done_core,
    output logic            req_any,
    output logic            sel,
    output req_kind_t       kind
);

    logic            rr;
    logic [CPUS-1:0] d_req;
    logic [CPUS-1:0] pool;

    // Pick the request class, then the core within it, then the transaction kind.
    always_comb begin
        d_req   = dREN | dWEN;
        pool    = (|d_req) ? d_req : iREN;
        req_any = |pool;
        sel     = pool[rr] ? rr : ~rr;
        if (dREN[sel])
            kind = REQ_RD;
        else if (dWEN[sel])
            kind = REQ_WB;
        else
            kind = REQ_IF;
    end

    // After each finished transaction the other core gets the tie-break.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            rr <= 1'b0;
        else if (done)
            rr <= ~done_core;
    end

endmodule

// File: rtl/coherence_control.sv
// Bus-side coherence/memory controller for two cores: one RAM port shared by
// two icaches and two dcaches, MSI snooping with cache-to-cache supply.
module coherence_control
    import cpu_types_pkg::*;
(
    input  logic               CLK,
    input  logic               nRST,
    input  logic  [CPUS-1:0]   iREN,
    input  word_t [CPUS-1:0]   iaddr,
    output logic  [CPUS-1:0]   iwait,
    output word_t [CPUS-1:0]   iload,
    input  logic  [CPUS-1:0]   dREN,
    input  logic  [CPUS-1:0]   dWEN,
    input  word_t [CPUS-1:0]   daddr,
    input  word_t [CPUS-1:0]   dstore,
    output logic  [CPUS-1:0]   dwait,
    output word_t [CPUS-1:0]   dload,
    input  logic  [CPUS-1:0]   cctrans,
    input  logic  [CPUS-1:0]   ccwrite,
    output logic  [CPUS-1:0]   ccwait,
    output logic  [CPUS-1:0]   ccinv,
    output word_t [CPUS-1:0]   ccsnoopaddr,
    output logic               ramREN,
    output logic               ramWEN,
    output word_t              ramaddr,
    output word_t              ramstore,
    input  word_t              ramload,
    input  ramstate_t          ramstate
);

    cc_state_t state;
    cc_state_t next_state;
    logic      g;
    logic      p;
    logic      word;
    logic      word_done;
    logic      done;
    logic      access;
    logic      req_any;
    logic      sel;
    req_kind_t kind;

    // cctrans carries no information the controller needs.
    logic unused_cctrans;
    assign unused_cctrans = ^cctrans;

    assign p      = ~g;
    assign access = (ramstate == ACCESS);

    cc_arbiter u_arb (
        .CLK       (CLK),
        .nRST      (nRST),
        .iREN      (iREN),
        .dREN      (dREN),
        .dWEN      (dWEN),
        .done      (done),
        .done_core (g),
        .req_any   (req_any),
        .sel       (sel),
        .kind      (kind)
    );

    // State, granted core and block-word counter; word clears on every grant.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
            g     <= 1'b0;
            word  <= 1'b0;
        end else begin
            state <= next_state;
            if (state == IDLE && req_any) begin
                g    <= sel;
                word <= 1'b0;
            end else if (word_done) begin
                word <= ~word;
            end
        end
    end

    // Next state and all outputs, decoded from the state plus current inputs.
    always_comb begin
        next_state  = state;
        done        = 1'b0;
        word_done   = 1'b0;
        iwait       = '1;
        dwait       = '1;
        iload       = '0;
        dload       = '0;
        ccwait      = '0;
        ccinv       = '0;
        ccsnoopaddr = '0;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;
        case (state)
            IDLE: begin
                if (req_any) begin
                    case (kind)
                        REQ_RD:  next_state = SNP1;
                        REQ_WB:  next_state = WB;
                        default: next_state = IF;
                    endcase
                end
            end
            IF: begin
                ramREN   = 1'b1;
                ramaddr  = iaddr[g];
                iload[g] = ramload;
                if (access) begin
                    iwait[g]   = 1'b0;
                    next_state = IDLE;
                    done       = 1'b1;
                end
            end
            WB: begin
                // The writer keeps dWEN up across both words; dropping it ends the burst.
                if (dWEN[g]) begin
                    ramWEN   = 1'b1;
                    ramaddr  = daddr[g];
                    ramstore = dstore[g];
                    if (access)
                        dwait[g] = 1'b0;
                end else begin
                    next_state = IDLE;
                    done       = 1'b1;
                end
            end
            SNP1, SNP2: begin
                ccwait[p]      = 1'b1;
                ccsnoopaddr[p] = daddr[g];
                ccinv[p]       = ccwrite[g];
                if (state == SNP1)
                    next_state = SNP2;
                else
                    next_state = ccwrite[p] ? C2C : LD;
            end
            LD: begin
                ccwait[p]      = 1'b1;
                ccsnoopaddr[p] = daddr[g];
                ramREN         = 1'b1;
                ramaddr        = daddr[g];
                dload[g]       = ramload;
                if (access) begin
                    dwait[g]  = 1'b0;
                    word_done = 1'b1;
                    if (word) begin
                        next_state = IDLE;
                        done       = 1'b1;
                    end
                end
            end
            C2C: begin
                // Peer supplies the word; writing it to RAM at the same time cleans the block.
                ccwait[p]      = 1'b1;
                ccsnoopaddr[p] = daddr[g];
                dload[g]       = dstore[p];
                if (dWEN[p]) begin
                    ramWEN   = 1'b1;
                    ramaddr  = daddr[p];
                    ramstore = dstore[p];
                    if (access) begin
                        dwait[g]  = 1'b0;
                        dwait[p]  = 1'b0;
                        word_done = 1'b1;
                        if (word) begin
                            next_state = IDLE;
                            done       = 1'b1;
                        end
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_coherence_control.sv
// Directed and randomized bench for coherence_control with a RAM responder
// and a memory-image reference model.
module tb_coherence_control;
    import cpu_types_pkg::*;

    logic          CLK = 1'b0;
    logic          nRST;
    logic  [1:0]   iREN, dREN, dWEN, cctrans, ccwrite;
    word_t [1:0]   iaddr, daddr, dstore;
    logic  [1:0]   iwait, dwait, ccwait, ccinv;
    word_t [1:0]   iload, dload, ccsnoopaddr;
    logic          ramREN, ramWEN;
    word_t         ramaddr, ramstore, ramload;
    ramstate_t     ramstate;

    int    total = 0;
    int    bad   = 0;
    int    rr_model = 0;
    int    busy_fixed = 2;
    int    busy_left = -1;
    logic  pend_we = 1'b0;
    int    pend_idx = 0;
    word_t pend_data = '0;
    word_t ram_mem [0:255];
    word_t ref_mem [0:255];

    coherence_control dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .cctrans(cctrans), .ccwrite(ccwrite), .ccwait(ccwait), .ccinv(ccinv),
        .ccsnoopaddr(ccsnoopaddr),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    // clock
    always #5 CLK = ~CLK;

    function automatic word_t seed_word(input int i);
        return (i == 16) ? 32'hDEADBEEF : (32'(i) * 32'h9E3779B9) ^ 32'h5A5A0000;
    endfunction

    function automatic int idx(input word_t a);
        return int'(a[9:2]);
    endfunction

    // RAM responder: random or fixed BUSY count, then one ACCESS per word.
    initial begin
        for (int i = 0; i < 256; i++) ram_mem[i] = seed_word(i);
        ramstate = FREE;
        ramload  = '0;
        forever begin
            @(posedge CLK);
            if (pend_we) begin
                ram_mem[pend_idx] = pend_data;
                pend_we = 1'b0;
            end
            #2;
            if (!nRST || !(ramREN || ramWEN)) begin
                ramstate  = FREE;
                busy_left = -1;
            end else begin
                if (busy_left < 0)
                    busy_left = (busy_fixed >= 0) ? busy_fixed : int'($urandom_range(0, 2));
                if (busy_left > 0) begin
                    ramstate = BUSY;
                    busy_left--;
                end else begin
                    ramstate  = ACCESS;
                    busy_left = -1;
                    ramload   = ram_mem[idx(ramaddr)];
                    if (ramWEN) begin
                        pend_we   = 1'b1;
                        pend_idx  = idx(ramaddr);
                        pend_data = ramstore;
                    end
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic adv();
        @(posedge CLK);
        #1;
    endtask

    task automatic smp();
        @(negedge CLK);
    endtask

    task automatic reset_chk(input string tag);
        chk({tag, "_iwait"}, 32'(iwait), 32'h3);
        chk({tag, "_dwait"}, 32'(dwait), 32'h3);
        chk({tag, "_ccwait"}, 32'(ccwait), 32'h0);
        chk({tag, "_ccinv"}, 32'(ccinv), 32'h0);
        chk({tag, "_ram_en"}, 32'({ramREN, ramWEN}), 32'h0);
        chk({tag, "_ramaddr"}, ramaddr, 32'h0);
        chk({tag, "_ramstore"}, ramstore, 32'h0);
        for (int c = 0; c < 2; c++) begin
            chk({tag, "_snoopaddr"}, ccsnoopaddr[c], 32'h0);
            chk({tag, "_dload"}, dload[c], 32'h0);
            chk({tag, "_iload"}, iload[c], 32'h0);
        end
    endtask

    // icache fetch of one word; also checks iwait is low for a single cycle.
    task automatic do_ifetch(input int c, input word_t a, output word_t data);
        bit got;
        got  = 1'b0;
        data = '0;
        iaddr[c] = a;
        iREN[c]  = 1'b1;
        for (int k = 0; k < 40 && !got; k++) begin
            smp();
            if (!iwait[c]) begin
                got  = 1'b1;
                data = iload[c];
                chk("if_ramren", 32'(ramREN), 32'h1);
                chk("if_ramaddr", ramaddr, a);
            end
            adv();
        end
        iREN[c] = 1'b0;
        chk("if_done", 32'(got), 32'h1);
        smp();
        chk("if_wait_single", 32'(iwait[c]), 32'h1);
        adv();
        rr_model = 1 - c;
    endtask

    // dcache two-word writeback.
    task automatic do_wb(input int c, input word_t a, input word_t d0, input word_t d1);
        bit got;
        bit ccw_seen;
        ccw_seen = 1'b0;
        daddr[c]  = a;
        dstore[c] = d0;
        dWEN[c]   = 1'b1;
        for (int w = 0; w < 2; w++) begin
            got = 1'b0;
            for (int k = 0; k < 40 && !got; k++) begin
                smp();
                if (ccwait != 2'b00) ccw_seen = 1'b1;
                if (!dwait[c]) begin
                    got = 1'b1;
                    chk("wb_ramwen", 32'(ramWEN), 32'h1);
                    chk("wb_ramaddr", ramaddr, a + 32'(4 * w));
                    chk("wb_ramstore", ramstore, (w == 0) ? d0 : d1);
                end
                adv();
            end
            chk("wb_word_done", 32'(got), 32'h1);
            daddr[c]  = a + 32'h4;
            dstore[c] = d1;
        end
        dWEN[c] = 1'b0;
        smp();
        chk("wb_no_ccwait", 32'(ccw_seen), 32'h0);
        adv();
        ref_mem[idx(a)]     = d0;
        ref_mem[idx(a) + 1] = d1;
        rr_model = 1 - c;
    endtask

    // dcache block fill with snoop; dirty peer supplies the block cache-to-cache.
    task automatic do_rd(input int c, input word_t a, input logic intent, input logic dirty,
                         input word_t pd0, input word_t pd1);
        int    p;
        int    words;
        int    snp;
        bit    peer_go;
        word_t exp_d;
        p = 1 - c;
        words = 0;
        snp = 0;
        daddr[c]   = a;
        ccwrite[c] = intent;
        cctrans[c] = 1'b1;
        dREN[c]    = 1'b1;
        for (int k = 0; k < 60 && words < 2; k++) begin
            smp();
            peer_go = 1'b0;
            if (ccwait[p] && !ramREN && !ramWEN) begin
                snp++;
                peer_go = dirty;
                chk("snp_inv", 32'(ccinv[p]), 32'(intent));
                chk("snp_addr", ccsnoopaddr[p], a);
            end else begin
                chk("inv_outside_snp", 32'(ccinv), 32'h0);
            end
            if (!dwait[c]) begin
                exp_d = dirty ? ((words == 0) ? pd0 : pd1) : ref_mem[idx(a) + words];
                chk("rd_data", dload[c], exp_d);
                chk("rd_ramaddr", ramaddr, a + 32'(4 * words));
                if (dirty) begin
                    chk("c2c_ramwen", 32'(ramWEN), 32'h1);
                    chk("c2c_ramstore", ramstore, exp_d);
                    chk("c2c_peer_wait", 32'(dwait[p]), 32'h0);
                end else begin
                    chk("ld_ramren", 32'(ramREN), 32'h1);
                end
                words++;
            end
            adv();
            if (peer_go) begin
                ccwrite[p] = 1'b1;
                cctrans[p] = 1'b1;
                dWEN[p]    = 1'b1;
                daddr[p]   = a;
                dstore[p]  = pd0;
            end
            if (words == 1) begin
                daddr[c] = a + 32'h4;
                if (dirty) begin
                    daddr[p]  = a + 32'h4;
                    dstore[p] = pd1;
                end
            end
        end
        chk("rd_words", 32'(words), 32'h2);
        dREN[c] = 1'b0;
        dWEN[p] = 1'b0;
        ccwrite = 2'b00;
        cctrans = 2'b00;
        smp();
        chk("rd_ccwait_drop", 32'(ccwait), 32'h0);
        chk("rd_snoop_cycles", 32'(snp), 32'h2);
        adv();
        if (dirty) begin
            ref_mem[idx(a)]     = pd0;
            ref_mem[idx(a) + 1] = pd1;
        end
        rr_model = p;
    endtask

    // Both dcaches and icache 0 request together: rr core, other core, then icache.
    task automatic do_arb(input word_t a0, input word_t a1, input word_t a2);
        int         wc [2];
        word_t      base [2];
        int         order_q [$];
        logic [1:0] exp_q [$];
        base[0] = a0;
        base[1] = a1;
        wc[0] = 0;
        wc[1] = 0;
        exp_q.push_back(2'(rr_model));
        exp_q.push_back(2'(1 - rr_model));
        exp_q.push_back(2'd2);
        ccwrite  = 2'b00;
        cctrans  = 2'b11;
        daddr[0] = a0;
        daddr[1] = a1;
        iaddr[0] = a2;
        dREN     = 2'b11;
        iREN[0]  = 1'b1;
        for (int k = 0; k < 150 && order_q.size() < 3; k++) begin
            smp();
            for (int c = 0; c < 2; c++) begin
                if (!dwait[c] && dREN[c]) begin
                    chk("arb_dload", dload[c], ref_mem[idx(base[c]) + wc[c]]);
                    wc[c]++;
                    if (wc[c] == 2) order_q.push_back(c);
                end
            end
            if (!iwait[0] && iREN[0]) begin
                chk("arb_iload", iload[0], ref_mem[idx(a2)]);
                order_q.push_back(2);
            end
            adv();
            for (int c = 0; c < 2; c++) begin
                if (wc[c] == 1) daddr[c] = base[c] + 32'h4;
                if (wc[c] == 2) dREN[c] = 1'b0;
            end
            if (order_q.size() > 0 && order_q[order_q.size() - 1] == 2) iREN[0] = 1'b0;
        end
        dREN    = 2'b00;
        iREN    = 2'b00;
        cctrans = 2'b00;
        chk("arb_count", 32'(order_q.size()), 32'h3);
        for (int i = 0; i < order_q.size() && i < 3; i++)
            chk("arb_order", 32'(order_q[i]), 32'(exp_q[i]));
        rr_model = 1;
    endtask

    // directed steps, then randomized transactions
    initial begin
        word_t d;
        int    diffs;
        bit    aborted;
        bit    peer_go;
        int    kind;
        int    c;
        word_t a;

        for (int i = 0; i < 256; i++) ref_mem[i] = seed_word(i);
        nRST = 1'b0;
        iREN = '0; dREN = '0; dWEN = '0; cctrans = '0; ccwrite = '0;
        iaddr = '0; daddr = '0; dstore = '0;
        #2;
        reset_chk("rst");
        adv();
        adv();
        nRST = 1'b1;

        // icache fetch with two BUSY cycles
        busy_fixed = 2;
        do_ifetch(0, 32'h40, d);
        chk("if_deadbeef", d, 32'hDEADBEEF);
        busy_fixed = -1;

        // writeback from core 1
        do_wb(1, 32'h80, 32'h11, 32'h22);

        // clean read miss, no write intent
        do_rd(0, 32'h100, 1'b0, 1'b0, '0, '0);

        // read with write intent, peer dirty: cache-to-cache
        do_rd(0, 32'h200, 1'b1, 1'b1, 32'hA, 32'hB);

        // simultaneous requests
        do_arb(32'h180, 32'h1C0, 32'h48);

        // reset during C2C word 0
        busy_fixed = 6;
        daddr[0]   = 32'h300;
        ccwrite[0] = 1'b1;
        cctrans[0] = 1'b1;
        dREN[0]    = 1'b1;
        aborted    = 1'b0;
        for (int k = 0; k < 30 && !aborted; k++) begin
            smp();
            if (ramWEN) begin
                nRST = 1'b0;
                #1;
                reset_chk("abort");
                aborted = 1'b1;
            end else begin
                peer_go = ccwait[1];
                adv();
                if (peer_go) begin
                    ccwrite[1] = 1'b1;
                    dWEN[1]    = 1'b1;
                    daddr[1]   = 32'h300;
                    dstore[1]  = 32'hC0DE0001;
                end
            end
        end
        chk("abort_reached", 32'(aborted), 32'h1);
        adv();
        dREN = '0; dWEN = '0; ccwrite = '0; cctrans = '0;
        adv();
        nRST = 1'b1;
        rr_model = 0;
        for (int k = 0; k < 3; k++) begin
            smp();
            chk("post_rst_ramwen", 32'(ramWEN), 32'h0);
            chk("post_rst_idle", 32'({ccwait, dwait, iwait}), 32'h0F);
            adv();
        end
        busy_fixed = -1;

        // randomized single-core transactions
        for (int t = 0; t < 24; t++) begin
            kind = int'($urandom_range(0, 3));
            c    = int'($urandom_range(0, 1));
            a    = 32'($urandom_range(0, 63)) << 3;
            case (kind)
                0: begin
                    a = a + 32'(4 * $urandom_range(0, 1));
                    do_ifetch(c, a, d);
                    chk("rnd_if", d, ref_mem[idx(a)]);
                end
                1: do_wb(c, a, $urandom, $urandom);
                2: do_rd(c, a, 1'($urandom_range(0, 1)), 1'b0, '0, '0);
                default: do_rd(c, a, 1'b1, 1'b1, $urandom, $urandom);
            endcase
        end

        do_arb(32'h1E0, 32'h1E8, 32'h1F4);

        adv();
        diffs = 0;
        for (int i = 0; i < 256; i++)
            if (ram_mem[i] !== ref_mem[i]) diffs++;
        chk("mem_image", 32'(diffs), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
